// File: rtl/mem_stage_dport.sv
// MEM-stage data-port controller: issues registered load/store requests,
// raises the memory stall, formats store lanes and extends load data.
module mem_stage_dport #(
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic        stall_in,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [31:0] r_data_out,
  output logic        mem_stall_out,
  output logic        misaligned_out
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, next_state;
  logic [31:0] lat_addr, lat_wdata, hold_q;
  logic [2:0]  lat_funct3;
  logic        lat_store;
  logic [3:0]  lat_mbe;

  logic        is_mem, is_store, misaligned, mem_op;
  logic [3:0]  fmt_mbe;
  logic [31:0] fmt_wdata, load_ext;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return rd;
    endcase
  endfunction

  // funct3[1:0] encodes access size for both loads and stores; 11 falls back to word.
  always_comb begin
    is_store   = opcode_in == OP_STORE;
    is_mem     = valid_in && (opcode_in == OP_LOAD || is_store);
    misaligned = 1'b0;
    if (MISALIGN_CHECK && is_mem) begin
      case (funct3_in[1:0])
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = addr_in[0];
        default: misaligned = |addr_in[1:0];
      endcase
    end
    mem_op = is_mem && !misaligned;
  end

  always_comb begin
    fmt_mbe   = 4'hF;
    fmt_wdata = '0;
    if (is_store) begin
      case (funct3_in[1:0])
        2'b00: begin
          fmt_mbe   = 4'b0001 << addr_in[1:0];
          fmt_wdata = {4{store_data_in[7:0]}};
        end
        2'b01: begin
          fmt_mbe   = 4'b0011 << {addr_in[1], 1'b0};
          fmt_wdata = {2{store_data_in[15:0]}};
        end
        default: begin
          fmt_mbe   = 4'hF;
          fmt_wdata = store_data_in;
        end
      endcase
    end
  end

  assign load_ext = extend(lat_funct3, lat_addr[1:0], dmem_rdata);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
      lat_store  <= 1'b0;
      lat_mbe    <= '0;
      hold_q     <= '0;
    end else begin
      if (state == IDLE && mem_op) begin
        lat_addr   <= addr_in;
        lat_wdata  <= fmt_wdata;
        lat_funct3 <= funct3_in;
        lat_store  <= is_store;
        lat_mbe    <= fmt_mbe;
      end
      if (state == BUSY && dmem_resp && !lat_store) hold_q <= load_ext;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (mem_op) next_state = BUSY;
      BUSY:    if (dmem_resp) next_state = stall_in ? DONE : IDLE;
      DONE:    if (!stall_in) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Combinational outputs are forced quiet while rst is held so nothing leaks out mid-reset.
  always_comb begin
    dmem_read      = 1'b0;
    dmem_write     = 1'b0;
    dmem_address   = '0;
    dmem_wdata     = '0;
    dmem_mbe       = '0;
    r_data_out     = hold_q;
    mem_stall_out  = 1'b0;
    misaligned_out = 1'b0;
    case (state)
      IDLE: begin
        mem_stall_out  = mem_op;
        misaligned_out = misaligned;
      end
      BUSY: begin
        dmem_read     = !lat_store;
        dmem_write    = lat_store;
        dmem_address  = {lat_addr[31:2], 2'b00};
        dmem_wdata    = lat_wdata;
        dmem_mbe      = lat_mbe;
        mem_stall_out = !dmem_resp;
        if (dmem_resp && !lat_store) r_data_out = load_ext;
      end
      default: ;
    endcase
    if (rst) begin
      mem_stall_out  = 1'b0;
      misaligned_out = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_dport.sv
// Bench for mem_stage_dport: directed scenarios plus random load/store traffic
// checked against a transaction-level model of the data port.
module tb_mem_stage_dport;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic        stall_in;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] r_data_out;
  logic        mem_stall_out;
  logic        misaligned_out;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic [31:0] m_hold  = '0;

  always #5 clk = ~clk;

  mem_stage_dport #(.MISALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .opcode_in(opcode_in),
    .funct3_in(funct3_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .stall_in(stall_in), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .r_data_out(r_data_out),
    .mem_stall_out(mem_stall_out), .misaligned_out(misaligned_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int unsigned m_size(input logic [2:0] f3);
    if (f3 % 4 == 0) return 1;
    if (f3 % 4 == 1) return 2;
    return 4;
  endfunction

  function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    int unsigned off;
    logic [31:0] b, h;
    off = a % 4;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] m_mbe(input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (!st || m_size(f3) == 4) return 4'hF;
    if (m_size(f3) == 1) return 4'(1 << (a % 4));
    return 4'(3 << (a % 4 / 2 * 2));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (m_size(f3) == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (m_size(f3) == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_rd"}, dmem_read, 1'b0);
    check({tag, "_wr"}, dmem_write, 1'b0);
    check({tag, "_mbe"}, dmem_mbe, 4'h0);
    check({tag, "_addr"}, dmem_address, 32'h0);
    check({tag, "_stall"}, mem_stall_out, 1'b0);
    check({tag, "_rdata"}, r_data_out, m_hold);
  endtask

  // One instruction through MEM: issue cycle, lat+1 BUSY cycles (response in the
  // last), then `hold` frozen cycles with stall_in released in the final one.
  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd,
                       input int unsigned lat, input int unsigned hold);
    bit mis, resp;
    mis = m_misaligned(f3, a);
    @(negedge clk);
    valid_in = 1'b1; opcode_in = st ? OP_STORE : OP_LOAD; funct3_in = f3;
    addr_in = a; store_data_in = sd; stall_in = 1'b0; dmem_resp = 1'b0; dmem_rdata = $urandom;
    #1;
    check("issue_mis", misaligned_out, mis);
    check("issue_rd", dmem_read, 1'b0);
    check("issue_wr", dmem_write, 1'b0);
    check("issue_stall", mem_stall_out, !mis);
    check("issue_rdata", r_data_out, m_hold);
    if (!mis) begin
      for (int i = 0; i <= int'(lat); i++) begin
        @(negedge clk);
        resp = (i == int'(lat));
        addr_in = $urandom; store_data_in = $urandom; funct3_in = 3'($urandom);
        dmem_resp = resp; dmem_rdata = resp ? rd : $urandom;
        stall_in = resp ? (hold > 0) : 1'($urandom);
        #1;
        check("busy_rd", dmem_read, !st);
        check("busy_wr", dmem_write, st);
        check("busy_addr", dmem_address, a & 32'hFFFF_FFFC);
        check("busy_mbe", dmem_mbe, m_mbe(st, f3, a));
        if (st) check("busy_wdata", dmem_wdata, m_wdata(f3, sd));
        check("busy_stall", mem_stall_out, !resp);
        if (resp && !st) m_hold = m_load(f3, a, rd);
        check("busy_rdata", r_data_out, m_hold);
      end
      for (int h = 0; h < int'(hold); h++) begin
        @(negedge clk);
        dmem_resp = 1'b0; dmem_rdata = $urandom;
        stall_in = (h < int'(hold) - 1);
        #1;
        check_quiet("frozen");
      end
    end
    @(negedge clk);
    valid_in = 1'b0; stall_in = 1'b0; dmem_resp = 1'b0;
    #1;
    check_quiet("after");
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    bit          st;

    rst = 1'b1; valid_in = 1'b0; opcode_in = '0; funct3_in = '0; addr_in = '0;
    store_data_in = '0; stall_in = 1'b0; dmem_rdata = '0; dmem_resp = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    check_quiet("reset");
    check("reset_mis", misaligned_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // lb, response in third BUSY cycle
    do_op(1'b0, 3'b000, 32'h0000_1003, '0, 32'h80FF_1234, 2, 0);
    check("lb_value", r_data_out, 32'hFFFF_FF80);
    do_op(1'b0, 3'b101, 32'h0000_1002, '0, 32'h80FF_1234, 0, 0);
    check("lhu_value", r_data_out, 32'h0000_80FF);
    do_op(1'b0, 3'b001, 32'h0000_1000, '0, 32'h80FF_1234, 1, 0);
    check("lh_value", r_data_out, 32'h0000_1234);

    do_op(1'b1, 3'b000, 32'h0000_2001, 32'h0000_00AB, '0, 1, 0);
    do_op(1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234, '0, 0, 0);
    do_op(1'b1, 3'b010, 32'h0000_2004, 32'hCAFE_F00D, '0, 2, 0);
    check("store_keeps_rdata", r_data_out, 32'h0000_1234);

    do_op(1'b0, 3'b010, 32'h0000_1002, '0, 32'h1111_1111, 0, 0);
    check("mis_keeps_rdata", r_data_out, 32'h0000_1234);

    do_op(1'b0, 3'b010, 32'h0000_1000, '0, 32'hDEAD_BEEF, 0, 5);
    check("lw_frozen_value", r_data_out, 32'hDEAD_BEEF);

    // reset while BUSY, then a stray response
    @(negedge clk);
    valid_in = 1'b1; opcode_in = OP_LOAD; funct3_in = 3'b010; addr_in = 32'h0000_3000;
    @(negedge clk);
    #1;
    check("pre_reset_rd", dmem_read, 1'b1);
    rst = 1'b1; valid_in = 1'b0;
    @(negedge clk);
    m_hold = '0;
    #1;
    check_quiet("mid_reset");
    rst = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    check_quiet("late_resp");
    do_op(1'b0, 3'b010, 32'h0000_3000, '0, 32'h0BAD_F00D, 1, 0);
    check("post_reset_lw", r_data_out, 32'h0BAD_F00D);

    for (int n = 0; n < 150; n++) begin
      st = 1'($urandom);
      if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a - (a % m_size(f3));
      do_op(st, f3, a, $urandom, $urandom, $urandom_range(0, 3),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage_dport.md
Name: mem_stage_dport

Overview:
- MEMORY-stage data-port controller for the RV32I pipeline. Sits between the EX/MEM register and the data cache/memory, and drives the inputs of the MEM/WB register.
- Issues load/store requests with a request/response handshake, and generates the memory stall.
- Produces the byte-enable mask and lane-replicated store data.
- Aligns and sign/zero-extends load data into r_data for the MEM/WB register.

Parameters:
MISALIGN_CHECK, 1, 1 = detect misaligned accesses, flag them and never issue them; 0 = issue them, using address bits as-is.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
valid_in  in  1  EX/MEM holds a live instruction
opcode_in  in  7  rv32i_opcode from EX/MEM; op_load and op_store are the memory ops
funct3_in  in  3  access width/sign (load: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store: 000 sb, 001 sh, 010 sw)
addr_in  in  32  effective address (ALU result)
store_data_in  in  32  rs2 value
stall_in  in  1  pipeline freeze from other sources (e.g. icache miss)
dmem_read  out  1  read request
dmem_write  out  1  write request
dmem_address  out  32  {addr[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_mbe  out  4  byte enables
dmem_rdata  in  32  read data
dmem_resp  in  1  one-cycle completion pulse
r_data_out  out  32  extended load data, feeds MEM/WB r_data_in
mem_stall_out  out  1  memory stall, feeds the pipeline stall network
misaligned_out  out  1  misaligned access flag for the current instruction

Behaviour:
- FSM states:
  - IDLE: no request outstanding.
  - BUSY: request outstanding.
  - DONE: access complete, pipeline still frozen.
- Memory op (mem_op) = valid_in and opcode is load or store and not misaligned.
- IDLE -> BUSY on mem_op. At this edge, latch address, funct3, load/store, mbe and wdata.
- BUSY: dmem_read or dmem_write is held at 1, with address/mbe/wdata driven from the latched values, until dmem_resp.
  - Earliest response is the first BUSY cycle.
  - Requests are registered, so the first request cycle is one cycle after the op appears. Minimum MEM occupancy is 2 cycles.
- BUSY and dmem_resp:
  - If stall_in = 0 -> IDLE.
  - If stall_in = 1 -> DONE.
  - On a load, extended rdata is captured into the hold register in both cases.
- DONE: no request issued, mem_stall_out = 0, r_data_out comes from the hold register. DONE -> IDLE on the first cycle with stall_in = 0. This guarantees no duplicate issue while frozen.
- mem_stall_out is combinational:
  - 1 in IDLE when mem_op.
  - 1 in BUSY without dmem_resp.
  - 0 otherwise, including the response cycle, so MEM/WB latches that cycle.
- r_data_out:
  - In the response cycle: combinational extension of dmem_rdata.
  - In DONE: the hold register.
  - Otherwise: the hold register (last load value).
  - Stores do not modify it.
- Load extension uses the latched addr[1:0]:
  - lb/lbu: byte addr[1:0], sign/zero-extended.
  - lh/lhu: halfword at addr[1], sign/zero-extended.
  - lw: whole word.
  - Unknown funct3: treat as lw.
- Store formatting:
  - sb: mbe = 4'b0001 << addr[1:0], wdata = byte replicated x4.
  - sh: mbe = 4'b0011 << (2*addr[1]), wdata = halfword replicated x2.
  - sw: mbe = 4'b1111, wdata = rs2.
  - Loads: mbe = 4'b1111.
- Misalignment (MISALIGN_CHECK = 1): half access with addr[0] = 1, or word access with addr[1:0] != 0.
  - misaligned_out = 1 combinationally while the instruction is presented.
  - No request, no stall, r_data_out unchanged.
- valid_in = 0 or a non-memory opcode: no request, no stall, misaligned_out = 0.
- Inputs changing while BUSY are ignored (latched copy used).
- Outputs when idle: dmem_read = dmem_write = 0, dmem_address/wdata = 0, dmem_mbe = 0.
- Reset, including mid-operation:
  - FSM -> IDLE, hold register = 0, latched fields = 0.
  - All outputs 0 from the edge after rst: requests drop even if BUSY.
  - A dmem_resp arriving during or after reset while IDLE is ignored.

Test Plan:
1. lb at 0x0000_1003; resp after 3 BUSY cycles with rdata 0x80FF_1234 -> dmem_read held 3 cycles at address 0x0000_1000, mbe 4'hF; mem_stall_out high through the non-response cycles; r_data_out = 0xFFFF_FF80 in the resp cycle; mem_stall_out = 0 in that cycle.
2. lhu at 0x1002, rdata 0x80FF_1234 -> r_data_out = 0x0000_80FF; lh at 0x1000 with same rdata -> 0x0000_1234.
3. sb at 0x2001 with rs2 0x0000_00AB -> dmem_write = 1, mbe = 4'b0010, wdata = 0xABAB_ABAB; sh at 0x2002 with 0x1234 -> mbe = 4'b1100, wdata = 0x1234_1234; sw -> mbe = 4'hF.
4. lw at 0x1002 -> misaligned_out = 1, no dmem_read, mem_stall_out = 0, r_data_out unchanged.
5. lw resp (rdata 0xDEAD_BEEF) with stall_in = 1 held 4 more cycles -> DONE entered, no second dmem_read, r_data_out = 0xDEAD_BEEF throughout, IDLE after stall_in falls.
6. rst asserted while BUSY -> next cycle dmem_read = 0, mem_stall_out = 0, r_data_out = 0; a late dmem_resp is ignored; a following lw issues normally.
